// File: rtl/traffic_pkg.sv
// Shared definitions for the multi-phase traffic controller: phase encoding
// and the one-hot {red,yellow,green} light patterns.
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        SIDE_GREEN  = 3'd2,
        SIDE_YELLOW = 3'd3,
        PED_WALK    = 3'd4
    } state_t;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

endpackage

// File: rtl/multi_phase_traffic_controller_if.sv
// Sensor, timing and light signals of the traffic controller.
// The master side drives sensors and durations; the slave is the controller.
interface multi_phase_traffic_controller_if #(
    parameter int NUM_SIDE = 2,
    parameter int TIME_W   = 4
);
    logic                  tick;
    logic [NUM_SIDE-1:0]   car_async;
    logic                  ped_async;
    logic [TIME_W-1:0]     time_main;
    logic [TIME_W-1:0]     time_side;
    logic [TIME_W-1:0]     time_yellow;
    logic [TIME_W-1:0]     time_walk;
    logic [2:0]            main_light;
    logic [3*NUM_SIDE-1:0] side_light;
    logic                  walk;
    logic [1:0]            active_side;
    logic [TIME_W-1:0]     timer_value;

    modport master (
        output tick, car_async, ped_async,
        output time_main, time_side, time_yellow, time_walk,
        input  main_light, side_light, walk, active_side, timer_value
    );

    modport slave (
        input  tick, car_async, ped_async,
        input  time_main, time_side, time_yellow, time_walk,
        output main_light, side_light, walk, active_side, timer_value
    );
endinterface

// File: rtl/rr_side_arbiter.sv
// Sticky per-side request latches and round-robin selection of the next
// side to serve, starting just after the side served last.
module rr_side_arbiter #(
    parameter int NUM_SIDE = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_SIDE-1:0] car,
    input  logic                clr,
    input  logic [1:0]          clr_idx,
    input  logic [1:0]          last_served,
    output logic                any_pending,
    output logic [1:0]          winner
);
    logic [NUM_SIDE-1:0] pending;
    logic [NUM_SIDE-1:0] clr_mask;

    // Decode the side being granted this cycle into a clear mask.
    always_comb begin
        clr_mask = '0;
        for (int k = 0; k < NUM_SIDE; k++) begin
            clr_mask[k] = clr && (clr_idx == 2'(k));
        end
    end

    // Requests stick until their side is granted; a grant beats a new request.
    always_ff @(posedge clock) begin
        if (!reset) pending <= '0;
        else        pending <= (pending | car) & ~clr_mask;
    end

    assign any_pending = |pending;

    // Scan from farthest to nearest so the nearest pending side after
    // last_served is the one left in winner.
    always_comb begin
        winner = '0;
        for (int i = NUM_SIDE; i >= 1; i--) begin
            for (int k = 0; k < NUM_SIDE; k++) begin
                if (pending[k] && (k == (int'(last_served) + i) % NUM_SIDE)) winner = 2'(k);
            end
        end
    end
endmodule

// File: rtl/multi_phase_traffic_controller.sv
// Main road / side road / pedestrian phase sequencer.
//
// state       | meaning
// MAIN_GREEN  | main road green, held until timer done and a request waits
// MAIN_YELLOW | main road clearing
// SIDE_GREEN  | side active_side green
// SIDE_YELLOW | side active_side clearing
// PED_WALK    | all roads red, walk lamp on
module multi_phase_traffic_controller
    import traffic_pkg::*;
#(
    parameter int NUM_SIDE = 2,
    parameter int TIME_W   = 4
) (
    input logic clock,
    input logic reset,
    multi_phase_traffic_controller_if.slave bus
);
    state_t              state;
    logic [TIME_W-1:0]   timer;
    logic [NUM_SIDE-1:0] car_s1, car_s2;
    logic                ped_s1, ped_s2;
    logic                ped_pending, ped_turn;
    logic [1:0]          last_served;
    logic                any_pending;
    logic [1:0]          winner;
    logic                expired, yel_done, pick_ped, enter_side, enter_ped;

    // Zero-length phases would never expire cleanly, so they run one tick.
    function automatic logic [TIME_W-1:0] dur(input logic [TIME_W-1:0] d);
        return (d == '0) ? TIME_W'(1) : d;
    endfunction

    function automatic logic [3*NUM_SIDE-1:0] side_lights(input logic [1:0] idx,
                                                          input logic [2:0] col);
        logic [3*NUM_SIDE-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_SIDE; k++) v[3*k +: 3] = (idx == 2'(k)) ? col : RED;
        return v;
    endfunction

    // Two-flop synchronisers for the asynchronous sensors.
    always_ff @(posedge clock) begin
        if (!reset) begin
            car_s1 <= '0;
            car_s2 <= '0;
            ped_s1 <= 1'b0;
            ped_s2 <= 1'b0;
        end else begin
            car_s1 <= bus.car_async;
            car_s2 <= car_s1;
            ped_s1 <= bus.ped_async;
            ped_s2 <= ped_s1;
        end
    end

    assign expired    = bus.tick && (timer <= TIME_W'(1));
    assign yel_done   = (state == MAIN_YELLOW) && expired;
    assign pick_ped   = ped_pending && (ped_turn || !any_pending);
    assign enter_ped  = yel_done && pick_ped;
    assign enter_side = yel_done && !pick_ped && any_pending;

    rr_side_arbiter #(.NUM_SIDE(NUM_SIDE)) u_arb (
        .clock       (clock),
        .reset       (reset),
        .car         (car_s2),
        .clr         (enter_side),
        .clr_idx     (winner),
        .last_served (last_served),
        .any_pending (any_pending),
        .winner      (winner)
    );

    // Phase sequencing; lights are set alongside the state they belong to.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= MAIN_GREEN;
            timer           <= dur(bus.time_main);
            ped_pending     <= 1'b0;
            ped_turn        <= 1'b0;
            last_served     <= 2'(NUM_SIDE - 1);
            bus.active_side <= 2'd0;
            bus.main_light  <= GREEN;
            bus.side_light  <= side_lights(2'd0, RED);
            bus.walk        <= 1'b0;
        end else begin
            ped_pending <= enter_ped ? 1'b0 : (ped_pending | ped_s2);
            case (state)
                MAIN_GREEN: begin
                    if (expired && (any_pending || ped_pending)) begin
                        state          <= MAIN_YELLOW;
                        timer          <= dur(bus.time_yellow);
                        bus.main_light <= YELLOW;
                    end else if (bus.tick && timer != '0) begin
                        timer <= timer - 1'b1;
                    end
                end
                MAIN_YELLOW: begin
                    if (enter_ped) begin
                        state          <= PED_WALK;
                        timer          <= dur(bus.time_walk);
                        bus.main_light <= RED;
                        bus.walk       <= 1'b1;
                    end else if (enter_side) begin
                        state           <= SIDE_GREEN;
                        timer           <= dur(bus.time_side);
                        bus.main_light  <= RED;
                        bus.active_side <= winner;
                        bus.side_light  <= side_lights(winner, GREEN);
                    end else if (expired) begin
                        state          <= MAIN_GREEN;
                        timer          <= dur(bus.time_main);
                        bus.main_light <= GREEN;
                    end else if (bus.tick) begin
                        timer <= timer - 1'b1;
                    end
                end
                SIDE_GREEN: begin
                    if (expired) begin
                        state          <= SIDE_YELLOW;
                        timer          <= dur(bus.time_yellow);
                        bus.side_light <= side_lights(bus.active_side, YELLOW);
                    end else if (bus.tick) begin
                        timer <= timer - 1'b1;
                    end
                end
                SIDE_YELLOW: begin
                    if (expired) begin
                        state           <= MAIN_GREEN;
                        timer           <= dur(bus.time_main);
                        last_served     <= bus.active_side;
                        ped_turn        <= 1'b1;
                        bus.active_side <= 2'd0;
                        bus.main_light  <= GREEN;
                        bus.side_light  <= side_lights(2'd0, RED);
                    end else if (bus.tick) begin
                        timer <= timer - 1'b1;
                    end
                end
                PED_WALK: begin
                    if (expired) begin
                        state          <= MAIN_GREEN;
                        timer          <= dur(bus.time_main);
                        ped_turn       <= 1'b0;
                        bus.main_light <= GREEN;
                        bus.walk       <= 1'b0;
                    end else if (bus.tick) begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state           <= MAIN_GREEN;
                    timer           <= dur(bus.time_main);
                    bus.active_side <= 2'd0;
                    bus.main_light  <= GREEN;
                    bus.side_light  <= side_lights(2'd0, RED);
                    bus.walk        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.timer_value = timer;
endmodule
